// File: rtl/matvec_controller.sv
// Matrix-vector sequencer: latches x on start, then streams M rows through one
// shared combinational dot-product unit into a one-entry valid/ready result stage.

module inner_product #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int OW = 2*DW + 32
) (
    input  logic [DW*N-1:0] a,
    input  logic [DW*N-1:0] b,
    output logic [OW-1:0]   dot
);
    localparam int PW = 2*DW;

    logic [PW-1:0] prod;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        dot  = '0;
        prod = '0;
        for (int i = 0; i < N; i++) begin
            prod = PW'(a[i*DW +: DW]) * PW'(b[i*DW +: DW]);
            dot  = dot + OW'(prod);
        end
    end
endmodule

module matvec_controller #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int M  = 4,
    parameter int OW = 2*DW + $bits(N),
    parameter int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DW*N-1:0] vec_in,
    output logic            busy,
    input  logic            row_valid,
    output logic            row_ready,
    input  logic [DW*N-1:0] row_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [OW-1:0]   res_data,
    output logic [IW-1:0]   res_idx,
    output logic            res_last,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    state_t          state_q, state_d;
    logic [DW*N-1:0] vec_q;
    logic [IW-1:0]   cnt_q;
    logic [OW-1:0]   dot;
    logic            accept;
    logic            handshake;

    inner_product #(.N(N), .DW(DW), .OW(OW)) u_dot (
        .a   (vec_q),
        .b   (row_data),
        .dot (dot)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        row_ready = 1'b0;
        accept    = 1'b0;
        handshake = res_valid && res_ready;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                row_ready = !res_valid || res_ready;
                accept    = row_valid && row_ready;
                if (accept && cnt_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: begin
                if (handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == DRAIN) && handshake;
            if (state_q == IDLE && start) begin
                vec_q <= vec_in;
                cnt_q <= '0;
            end
            // A simultaneous accept reloads the stage, so it takes priority over the clear.
            if (accept) begin
                res_valid <= 1'b1;
                res_data  <= dot;
                res_idx   <= cnt_q;
                res_last  <= (cnt_q == LAST_IDX);
                cnt_q     <= cnt_q + IW'(1);
            end else if (handshake) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/matvec_controller.md
# matvec_controller

Sequencing controller that computes y = A·x by time-sharing one combinational `inner_product` instance across the M rows of A. The controller latches the vector x on `start`, then accepts matrix rows one per handshake and feeds each row with x into the dot-product datapath. Each result is registered into a one-entry output stage with a valid/ready handshake. It sits between the row-source (memory reader or upstream FIFO) and the result consumer.

## Interface
- `N`, 4: vector length / elements per row (N ≥ 1).
- `DW`, 8: element width, unsigned.
- `M`, 4: rows per matrix (M ≥ 1).
- `OW`, derived as 2*DW + $bits(N): result width, identical to `inner_product` output width.
- `IW`, derived as max(1, $clog2(M)): row-index width.
- `clk`  in  1  the single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin job; sampled only in IDLE.
- `vec_in`  in  DW*N  packed x, element i at [(i+1)*DW-1 : i*DW]; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `row_valid`  in  1  row beat offered.
- `row_ready`  out  1  controller can accept a row this cycle.
- `row_data`  in  DW*N  packed row, same packing as `vec_in`.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  OW  dot product of x and the row, unsigned.
- `res_idx`  out  IW  row index 0..M-1 of `res_data`.
- `res_last`  out  1  high with the result for row M-1.
- `done`  out  1  one-cycle pulse after the final result handshake.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 → latch `vec_in` into the vector register, clear row counter, go to RUN. `start` is ignored in RUN/DRAIN; the vector register is never modified outside IDLE.
- RUN: `row_ready` = !`res_valid` | `res_ready`. Row accept = `row_valid` & `row_ready`. On accept: `res_data` ← inner_product(vec_reg, `row_data`); `res_idx` ← counter; `res_last` ← (counter == M-1); `res_valid` ← 1; counter increments. Accept of row M-1 → DRAIN.
- Result handshake (`res_valid` & `res_ready`) without a simultaneous row accept clears `res_valid`. With a simultaneous accept, the register reloads and `res_valid` stays 1.
- DRAIN: `row_ready`=0. Handshake of the last result → `res_valid`←0, `done`←1 for one cycle, go to IDLE.
- Arithmetic: unsigned products DW×DW→2*DW, summed into OW bits. No overflow is possible for any inputs (max N*(2^DW-1)^2 fits).
- M=1: the first accept goes directly to DRAIN.
- Row counter width IW. It never wraps within a job; reset to 0 on each `start`.
- Reset (`rst_n`=0 at an edge, in any state including mid-job) → IDLE, counter 0, `res_valid`=0, `done`=0, `busy`=0, `res_data`/`res_idx`/`res_last`/vector register = 0. An in-flight result is discarded.

## Timing
- All outputs are registered except `row_ready`, which is combinational from state, `res_valid`, and `res_ready`.
- `start` at edge t → `busy`=1 and `row_ready` eligible in cycle t+1.
- Row accepted at edge t → `res_valid`/`res_data` visible in cycle t+1 (latency 1).
- With `res_ready` held high, throughput is 1 row/cycle; an M-row job completes M+1 cycles after the first accept.
- `done` is high in the cycle after the final handshake, with `busy`=0 in that same cycle. A `start` sampled in that cycle is accepted.
- `res_data`/`res_idx`/`res_last` are held stable while `res_valid`=1 and `res_ready`=0.

## Test plan
- Reset check: assert `rst_n`=0 for 2 cycles with random inputs → all outputs 0 and `row_ready`=0.
- Identity rows: N=4, M=4, x={1,2,3,4}, rows e0..e3, `res_ready`=1 → results 1,2,3,4 on consecutive cycles; `res_idx` 0..3; `res_last` only on idx 3; `done` one cycle later.
- Max values: all elements 255 → every `res_data` = 260100, no truncation.
- Backpressure: `res_ready` toggles 0,0,1 pattern while `row_valid`=1 → `row_ready` low whenever `res_valid`=1 & `res_ready`=0; results held stable; no row lost or duplicated; order preserved.
- Start while busy: pulse `start` with new `vec_in` during RUN → ignored; all results still use the original x.
- Reset mid-job: after 2 of 4 rows, `rst_n`=0 for one cycle → IDLE, `res_valid`=0, no `done`. A fresh job afterwards returns correct results starting at `res_idx`=0.
